compreng_sched: RTL

// - Search scheduler for the segment compare engine, a 5-stage reduction pipeline with no stall and no valid signal.
// - Accepts tagged search vectors over a valid/ready handshake and issues at most one vector per cycle.
// - Tracks in-flight searches with a shadow valid/tag pipe and pairs each engine result with its tag.
// - Buffers results in an output FIFO. Credit control guarantees no result is ever dropped under backpressure.

---
 rtl/compreng_sched_if.sv | 31 +++
 rtl/compreng_sched.sv | 125 ++++++++++++
 2 files changed

// File: rtl/compreng_sched_if.sv
// compreng_sched_if
//   Search-request and result handshakes of the compare-engine scheduler.
//   master : requester/consumer side (drives search request, result ready)
//   slave  : scheduler side (drives search ready, result valid/data/tag)
//   Search : i_Search_Valid, o_Search_Ready, i_Search_Vector[VTWID], i_Search_Tag[TAGWID]
//   Result : o_Result_Valid, i_Result_Ready, o_Result_Data[SEGWID], o_Result_Tag[TAGWID]
interface compreng_sched_if #(
    parameter int SEGWID = 10,
    parameter int VTWID  = 130,
    parameter int TAGWID = 4
);
    logic              i_Search_Valid;
    logic              o_Search_Ready;
    logic [VTWID-1:0]  i_Search_Vector;
    logic [TAGWID-1:0] i_Search_Tag;

    logic              o_Result_Valid;
    logic              i_Result_Ready;
    logic [SEGWID-1:0] o_Result_Data;
    logic [TAGWID-1:0] o_Result_Tag;

    modport master (
        output i_Search_Valid, i_Search_Vector, i_Search_Tag, i_Result_Ready,
        input  o_Search_Ready, o_Result_Valid, o_Result_Data, o_Result_Tag
    );

    modport slave (
        input  i_Search_Valid, i_Search_Vector, i_Search_Tag, i_Result_Ready,
        output o_Search_Ready, o_Result_Valid, o_Result_Data, o_Result_Tag
    );
endinterface

// File: rtl/compreng_sched.sv
// compreng_sched
//   Search scheduler for the segment compare engine (fixed-latency, no stall,
//   no valid). Issues at most one search per cycle, tracks in-flight searches
//   in a shadow valid/tag pipe, pairs each engine result with its tag and
//   buffers it in a show-ahead FIFO. Credit control keeps FIFO pushes lossless.
//   Ports:
//     clk, rst        clock, synchronous active-high reset (shared with engine)
//     sif (slave)     search request and result handshakes
//     o_Eng_Vector    registered vector to engine (zero when nothing issued)
//     i_Eng_Result    engine result, ENG_LAT cycles after o_Eng_Vector
//     o_Inflight      searches issued but not yet pushed into the FIFO
//     o_Accept_Count  accepted searches, wrapping 16-bit count
//     o_Busy          anything in flight or buffered
module compreng_sched #(
    parameter int SEGWID  = 10,
    parameter int VTWID   = 130,
    parameter int ENG_LAT = 5,
    parameter int TAGWID  = 4,
    parameter int FIFODEP = 8,
    parameter int FAW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    compreng_sched_if.slave   sif,
    output logic [VTWID-1:0]  o_Eng_Vector,
    input  logic [SEGWID-1:0] i_Eng_Result,
    output logic [2:0]        o_Inflight,
    output logic [15:0]       o_Accept_Count,
    output logic              o_Busy
);
    localparam int CNTW = FAW + 1;
    localparam int SUMW = FAW + 2;

    logic                accept;
    logic [ENG_LAT:0]    sh_v;
    logic [TAGWID-1:0]   sh_tag [ENG_LAT+1];
    logic                push;
    logic                pop;
    logic [FAW-1:0]      wr_ptr;
    logic [FAW-1:0]      rd_ptr;
    logic [CNTW-1:0]     fifo_cnt;
    logic [SEGWID-1:0]   mem_data [FIFODEP];
    logic [TAGWID-1:0]   mem_tag  [FIFODEP];
    logic [SUMW-1:0]     credit_used;

    // Searches still inside the engine hold a reserved FIFO slot, so the
    // exit push always finds room. A pop in the same cycle is not credited.
    always_comb begin
        credit_used        = SUMW'(fifo_cnt) + SUMW'(o_Inflight);
        sif.o_Search_Ready = !rst && (credit_used < SUMW'(FIFODEP));
    end

    assign accept = sif.i_Search_Valid && sif.o_Search_Ready;

    always_comb begin
        o_Inflight = '0;
        for (int unsigned i = 0; i <= ENG_LAT; i++) begin
            o_Inflight = o_Inflight + 3'(sh_v[i]);
        end
    end

    // Shadow valid pipe runs in lockstep with the engine registers; entry
    // ENG_LAT lines up with the result currently on i_Eng_Result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_v           <= '0;
            o_Eng_Vector   <= '0;
            o_Accept_Count <= '0;
        end else begin
            sh_v         <= {sh_v[ENG_LAT-1:0], accept};
            o_Eng_Vector <= accept ? sif.i_Search_Vector : '0;
            if (accept) begin
                o_Accept_Count <= o_Accept_Count + 16'd1;
            end
        end
    end

    // Tags need no reset: they are qualified by sh_v.
    always_ff @(posedge clk) begin
        sh_tag[0] <= sif.i_Search_Tag;
        for (int unsigned i = 1; i <= ENG_LAT; i++) begin
            sh_tag[i] <= sh_tag[i-1];
        end
    end

    assign push = sh_v[ENG_LAT];
    assign pop  = sif.o_Result_Valid && sif.i_Result_Ready;

    // Pointers wrap naturally because FIFODEP == 2**FAW.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FAW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FAW'(1);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CNTW'(1);
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= i_Eng_Result;
            mem_tag[wr_ptr]  <= sh_tag[ENG_LAT];
        end
    end

    assign sif.o_Result_Valid = (fifo_cnt != '0);
    assign sif.o_Result_Data  = mem_data[rd_ptr];
    assign sif.o_Result_Tag   = mem_tag[rd_ptr];
    assign o_Busy             = (o_Inflight != '0) || (fifo_cnt != '0);

    a_no_full_push: assert property (@(posedge clk) disable iff (rst)
        push |-> (fifo_cnt != CNTW'(FIFODEP)));

endmodule
